// File: rtl/hw_output_stream_packer_pkg.sv
// Shared types for the stencil output packer: FSM state, FIFO entry tags,
// and counter-width helpers.
package hls_stream_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    STREAM = 1'b1
  } state_t;

  // eof rides along so frame_done tracks the beat that actually leaves
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  localparam int DATA_W_DEF = 16;

  typedef struct packed {
    tag_t                  tag;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W_DEF = cw(64);
  localparam int ROW_W_DEF = cw(64);
  localparam int SKP_W_DEF = cw(2 + 1);
  localparam int CNT_W_DEF = cw(16 + 1);

endpackage

// File: rtl/hw_output_stream_packer_fifo.sv
// stream_fifo_sync: synchronous FIFO with a registered head-of-queue output.
// A push into an empty FIFO is visible on dout_o one cycle later.
module stream_fifo_sync #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = dout_q;

  // no bypass: a push while full is refused even if a pop frees a slot
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d   = do_push ? wr_q + PW'(1) : wr_q;
    rd_d   = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    dout_d = dout_q;
    if (cnt_d != '0) begin
      if (do_push && (cnt_q - CW'(do_pop)) == '0)
        dout_d = din_i;
      else
        dout_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/hw_output_stream_packer.sv
// Output packer: drops warm-up samples, tags SOF/EOL, buffers for backpressure.
// Define PACKER_STATS_EN to add frame_cnt / drop_cnt outputs.
module hw_output_stream_packer
  import hls_stream_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int SKIP       = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tuser,
  output logic              out_tlast,
  output logic              frame_done,
  output logic              overflow
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int COL_W = cw(IMG_W);
  localparam int ROW_W = cw(IMG_H);
  localparam int SKP_W = cw(SKIP + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = $bits(tag_t) + DATA_W;
  localparam state_t START = (SKIP == 0) ? STREAM : WARMUP;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SKP_W-1:0] skip_q, skip_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             push, pop, drop;
  tag_t             tag_in, out_tag;
  logic [ENT_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    skip_d  = skip_q;
    push    = 1'b0;
    tag_in  = '0;
    unique case (state_q)
      WARMUP: begin
        if (in_valid) begin
          skip_d = skip_q + SKP_W'(1);
          if (int'(skip_q) == SKIP - 1) begin
            state_d = STREAM;
            skip_d  = '0;
          end
        end
      end
      default: begin
        if (in_valid) begin
          push       = 1'b1;
          tag_in.sof = (col_q == '0) && (row_q == '0);
          tag_in.eol = col_q == COL_W'(IMG_W - 1);
          tag_in.eof = tag_in.eol && (row_q == ROW_W'(IMG_H - 1));
          if (tag_in.eol) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (tag_in.eof) begin
            row_d   = '0;
            skip_d  = '0;
            state_d = START;
          end
        end
      end
    endcase
  end

  // geometry advances on a drop too, keeping later frames aligned
  assign drop   = push && fifo_full;
  assign pop    = out_tready && !fifo_empty;
  assign ovf_d  = ovf_q | drop;
  assign done_d = pop && out_tag.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      col_q   <= '0;
      row_q   <= '0;
      skip_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      skip_q  <= skip_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  stream_fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({tag_in, in_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign {out_tag, out_tdata} = fifo_dout;
  assign out_tvalid = fifo_cnt != '0;
  assign out_tuser  = out_tag.sof;
  assign out_tlast  = out_tag.eol;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

`ifdef PACKER_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (done_q)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/hw_output_stream_packer.md
Name: hw_output_stream_packer

Overview:
- Sink end of a generated stencil pipeline: takes the free-running, valid-only pixel stream from the final output kernel and converts it to a backpressured AXI-Stream-style output.
- Discards line-buffer warm-up samples, tags start-of-frame (SOF) and end-of-line (EOL), and buffers in a FIFO to absorb downstream stalls.
- Sits between the last kernel instance and the top-level output port.

Parameters:
- DATA_W, 16, pixel width; matches kernel datapath width.
- IMG_W, 64, pixels per output row.
- IMG_H, 64, rows per frame.
- SKIP, 2, valid input samples discarded at the start of each frame (line-buffer fill latency).
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- in_valid, in, 1, kernel output sample valid; no backpressure toward the kernel.
- in_data, in, DATA_W, kernel output sample.
- out_tvalid, out, 1, output beat valid.
- out_tready, in, 1, downstream ready.
- out_tdata, out, DATA_W, output pixel.
- out_tuser, out, 1, SOF; set on pixel (0,0).
- out_tlast, out, 1, EOL; set on column IMG_W-1.
- frame_done, out, 1, one-cycle pulse when the beat at (IMG_W-1, IMG_H-1) handshakes.
- overflow, out, 1, sticky; set when a sample is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync deassert): out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, frame_done=0, overflow=0, FIFO empty, col=0, row=0, skip_cnt=0, state=WARMUP.
- Handshake: a beat transfers when out_tvalid && out_tready. While out_tvalid=1 and out_tready=0, out_tdata/out_tuser/out_tlast hold stable and out_tvalid stays 1.
- FIFO entry = {sof, eol, data}. The FIFO is registered; a push into an empty FIFO appears on the outputs the next cycle, so in-to-out latency is 1 cycle.
- State WARMUP:
  - Each in_valid increments skip_cnt; the sample is discarded.
  - When the SKIP-th valid sample arrives, go to STREAM on the next cycle; that sample is also discarded.
  - SKIP=0 means WARMUP is never entered; reset and frame wrap go straight to STREAM.
- State STREAM:
  - Each in_valid is pushed with sof=(col==0 && row==0) and eol=(col==IMG_W-1).
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1): push, clear col/row/skip_cnt, return to WARMUP for the next frame.
  - Data already in the FIFO keeps draining regardless of state.
- Full: full means count==FIFO_DEPTH on the registered count. A push at full is dropped even if a pop happens the same cycle (no bypass). On a drop, overflow is set and col/row still advance, so frame geometry stays aligned.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Empty: out_tvalid=0, outputs hold their last values.
- overflow clears only on reset.
- frame_done is asserted the cycle after the EOF beat handshakes. If that beat was dropped, no pulse is produced.
- Reset mid-frame: FIFO contents lost; counters and state return to reset values immediately.

Optional Feature:
- Macro PACKER_STATS_EN.
- When defined, two extra outputs:
  - frame_cnt [15:0]: increments on each frame_done pulse, wraps at 65535 to 0.
  - drop_cnt [15:0]: increments on each dropped sample, saturates at 65535.
  - Both reset to 0.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hls_stream_pkg holds:
  - state enum {WARMUP, STREAM};
  - the FIFO entry struct (sof, eol, data);
  - localparams for counter widths: clog2(IMG_W), clog2(IMG_H), clog2(SKIP+1), clog2(FIFO_DEPTH+1).
- One sub-module, stream_fifo_sync: synchronous FIFO with push/pop/full/empty/count and registered outputs, reusable for other output channels.
- The packer top holds the FSM, the col/row/skip counters and the flags.

Test Plan:
- IMG_W=4, IMG_H=2, SKIP=2, out_tready=1; feed values 1..10 on consecutive cycles -> values 1,2 discarded; 3..10 emitted; tuser only on 3; tlast on 6 and 10; frame_done pulses 1 cycle after the beat carrying 10.
- Same config, out_tready=0 throughout; feed 20 samples with FIFO_DEPTH=4 -> first 4 post-skip samples retained; overflow=1; after raising tready, exactly 4 beats out, with correct sof/eol on the retained entries.
- out_tready toggling 1,0,1,0 during streaming -> out_tdata stable on every stalled cycle; no loss, no duplication; output order equals input order.
- Two back-to-back frames with in_valid continuous -> the second frame also discards 2 samples; tuser is asserted once per frame; exactly 2 frame_done pulses.
- Assert rst_n=0 for 1 cycle mid-row with the FIFO holding 3 entries -> out_tvalid=0 during reset; the next frame restarts with the skip phase and tuser on its first kept pixel.
- PACKER_STATS_EN defined, overflow scenario with 16 samples dropped -> drop_cnt=16; frame_cnt=1 after one complete undropped frame.
